reorder_buffer: RTL and testbench

- Circular reorder buffer for the Tomasulo core: the responder end of the dispatcher's ROB alloc/query interface.
- Accepts one allocation per cycle from the dispatcher and hands back the allocated ROB id.
- Answers the dispatcher's two combinational operand-ready queries, captures results from the RS and LS CDBs, and commits one instruction per cycle in order.
- Commit targets: register file (writeback), LSB (store release) and fetcher/all units (rollback on branch mispredict).

---
 rtl/reorder_buffer.sv | 192 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands ROB ids to the dispatcher, captures RS/LS CDB results
// and retires one instruction per cycle in program order (writeback, store release, rollback).
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int ID_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            ena_from_dsp,
    input  logic [4:0]      rd_from_dsp,
    input  logic            is_store_from_dsp,
    input  logic            is_branch_from_dsp,
    input  logic            pred_taken_from_dsp,
    output logic [ID_W-1:0] rob_id_to_dsp,
    output logic            full_to_if,
    input  logic [ID_W-1:0] Q1_from_dsp,
    input  logic [ID_W-1:0] Q2_from_dsp,
    output logic            Q1_ready_to_dsp,
    output logic            Q2_ready_to_dsp,
    output logic [31:0]     data1_to_dsp,
    output logic [31:0]     data2_to_dsp,
    input  logic            valid_from_rs_cdb,
    input  logic [ID_W-1:0] rob_id_from_rs_cdb,
    input  logic [31:0]     result_from_rs_cdb,
    input  logic            taken_from_rs_cdb,
    input  logic [31:0]     target_pc_from_rs_cdb,
    input  logic            valid_from_ls_cdb,
    input  logic [ID_W-1:0] rob_id_from_ls_cdb,
    input  logic [31:0]     result_from_ls_cdb,
    output logic            commit_ena_to_reg,
    output logic [4:0]      commit_rd_to_reg,
    output logic [31:0]     commit_data_to_reg,
    output logic [ID_W-1:0] commit_rob_id_to_reg,
    output logic            commit_store_to_lsb,
    output logic [ID_W-1:0] commit_rob_id_to_lsb,
    output logic            rollback_flag,
    output logic [31:0]     target_pc_to_if
);

    localparam logic [ID_W-1:0] ZERO_ROB  = '0;
    localparam logic [ID_W-1:0] MAX_ID    = ID_W'(DEPTH);
    localparam logic [IDX_W:0]  CNT_FULL  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]  CNT_STALL = (IDX_W+1)'(DEPTH - 2);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] is_store_q;
    logic [DEPTH-1:0] is_branch_q;
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] taken_q;
    logic [4:0]       rd_q     [DEPTH];
    logic [31:0]      value_q  [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;
    logic             flush_pending;

    logic             live;
    logic             alloc_fire;
    logic             commit_fire;
    logic             mispredict;
    logic             rs_hit;
    logic             ls_hit;
    logic [IDX_W-1:0] rs_idx;
    logic [IDX_W-1:0] ls_idx;
    logic [IDX_W-1:0] q1_idx;
    logic [IDX_W-1:0] q2_idx;

    function automatic logic id_valid(input logic [ID_W-1:0] id);
        return (id != ZERO_ROB) && (id <= MAX_ID);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ID_W-1:0] id);
        return IDX_W'(id - ID_W'(1));
    endfunction

    assign rob_id_to_dsp = ID_W'(tail) + ID_W'(1);
    assign full_to_if    = (count >= CNT_STALL);

    always_comb begin
        q1_idx          = idx_of(Q1_from_dsp);
        q2_idx          = idx_of(Q2_from_dsp);
        Q1_ready_to_dsp = 1'b0;
        Q2_ready_to_dsp = 1'b0;
        data1_to_dsp    = '0;
        data2_to_dsp    = '0;
        if (id_valid(Q1_from_dsp)) begin
            Q1_ready_to_dsp = busy[q1_idx] && ready[q1_idx];
            data1_to_dsp    = value_q[q1_idx];
        end
        if (id_valid(Q2_from_dsp)) begin
            Q2_ready_to_dsp = busy[q2_idx] && ready[q2_idx];
            data2_to_dsp    = value_q[q2_idx];
        end
    end

    // The flush cycle after a mispredict ignores alloc, CDB and commit alike.
    always_comb begin
        live        = rdy && !flush_pending;
        rs_idx      = idx_of(rob_id_from_rs_cdb);
        ls_idx      = idx_of(rob_id_from_ls_cdb);
        alloc_fire  = live && ena_from_dsp && (count != CNT_FULL);
        commit_fire = live && (count != '0) && busy[head] && ready[head];
        mispredict  = commit_fire && is_branch_q[head] && (taken_q[head] != pred_q[head]);
        rs_hit      = live && valid_from_rs_cdb && id_valid(rob_id_from_rs_cdb) && busy[rs_idx];
        ls_hit      = live && valid_from_ls_cdb && id_valid(rob_id_from_ls_cdb) && busy[ls_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy          <= '0;
            ready         <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
        end else if (rdy) begin
            if (flush_pending) begin
                busy          <= '0;
                ready         <= '0;
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                flush_pending <= 1'b0;
            end else begin
                if (rs_hit) ready[rs_idx] <= 1'b1;
                if (ls_hit) ready[ls_idx] <= 1'b1;
                if (alloc_fire) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + IDX_W'(1);
                end
                if (commit_fire) begin
                    busy[head] <= 1'b0;
                    head       <= head + IDX_W'(1);
                end
                if (alloc_fire && !commit_fire)
                    count <= count + (IDX_W+1)'(1);
                else if (!alloc_fire && commit_fire)
                    count <= count - (IDX_W+1)'(1);
                flush_pending <= mispredict;
            end
        end
    end

    // Payload needs no reset: it is only observed through busy/ready.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_q[tail]        <= rd_from_dsp;
            is_store_q[tail]  <= is_store_from_dsp;
            is_branch_q[tail] <= is_branch_from_dsp;
            pred_q[tail]      <= pred_taken_from_dsp;
        end
        if (rs_hit) begin
            value_q[rs_idx]  <= result_from_rs_cdb;
            taken_q[rs_idx]  <= taken_from_rs_cdb;
            target_q[rs_idx] <= target_pc_from_rs_cdb;
        end
        if (ls_hit)
            value_q[ls_idx] <= result_from_ls_cdb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_ena_to_reg    <= 1'b0;
            commit_rd_to_reg     <= '0;
            commit_data_to_reg   <= '0;
            commit_rob_id_to_reg <= '0;
            commit_store_to_lsb  <= 1'b0;
            commit_rob_id_to_lsb <= '0;
            rollback_flag        <= 1'b0;
            target_pc_to_if      <= '0;
        end else begin
            commit_ena_to_reg   <= commit_fire && (rd_q[head] != 5'd0) && !is_store_q[head];
            commit_store_to_lsb <= commit_fire && is_store_q[head];
            rollback_flag       <= mispredict;
            if (commit_fire) begin
                commit_rd_to_reg     <= rd_q[head];
                commit_data_to_reg   <= value_q[head];
                commit_rob_id_to_reg <= ID_W'(head) + ID_W'(1);
                commit_rob_id_to_lsb <= ID_W'(head) + ID_W'(1);
            end
            if (mispredict)
                target_pc_to_if <= target_q[head];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: an in-order queue model predicts commits,
// a monitor compares every commit pulse; comb outputs are checked each cycle.
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        ena_from_dsp = 1'b0;
    logic [4:0]  rd_from_dsp = '0;
    logic        is_store_from_dsp = 1'b0;
    logic        is_branch_from_dsp = 1'b0;
    logic        pred_taken_from_dsp = 1'b0;
    logic [4:0]  rob_id_to_dsp;
    logic        full_to_if;
    logic [4:0]  Q1_from_dsp = '0;
    logic [4:0]  Q2_from_dsp = '0;
    logic        Q1_ready_to_dsp, Q2_ready_to_dsp;
    logic [31:0] data1_to_dsp, data2_to_dsp;
    logic        valid_from_rs_cdb = 1'b0;
    logic [4:0]  rob_id_from_rs_cdb = '0;
    logic [31:0] result_from_rs_cdb = '0;
    logic        taken_from_rs_cdb = 1'b0;
    logic [31:0] target_pc_from_rs_cdb = '0;
    logic        valid_from_ls_cdb = 1'b0;
    logic [4:0]  rob_id_from_ls_cdb = '0;
    logic [31:0] result_from_ls_cdb = '0;
    logic        commit_ena_to_reg;
    logic [4:0]  commit_rd_to_reg;
    logic [31:0] commit_data_to_reg;
    logic [4:0]  commit_rob_id_to_reg;
    logic        commit_store_to_lsb;
    logic [4:0]  commit_rob_id_to_lsb;
    logic        rollback_flag;
    logic [31:0] target_pc_to_if;

    reorder_buffer #(.DEPTH(16), .IDX_W(4), .ID_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ena_from_dsp(ena_from_dsp), .rd_from_dsp(rd_from_dsp),
        .is_store_from_dsp(is_store_from_dsp), .is_branch_from_dsp(is_branch_from_dsp),
        .pred_taken_from_dsp(pred_taken_from_dsp),
        .rob_id_to_dsp(rob_id_to_dsp), .full_to_if(full_to_if),
        .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
        .Q1_ready_to_dsp(Q1_ready_to_dsp), .Q2_ready_to_dsp(Q2_ready_to_dsp),
        .data1_to_dsp(data1_to_dsp), .data2_to_dsp(data2_to_dsp),
        .valid_from_rs_cdb(valid_from_rs_cdb), .rob_id_from_rs_cdb(rob_id_from_rs_cdb),
        .result_from_rs_cdb(result_from_rs_cdb), .taken_from_rs_cdb(taken_from_rs_cdb),
        .target_pc_from_rs_cdb(target_pc_from_rs_cdb),
        .valid_from_ls_cdb(valid_from_ls_cdb), .rob_id_from_ls_cdb(rob_id_from_ls_cdb),
        .result_from_ls_cdb(result_from_ls_cdb),
        .commit_ena_to_reg(commit_ena_to_reg), .commit_rd_to_reg(commit_rd_to_reg),
        .commit_data_to_reg(commit_data_to_reg), .commit_rob_id_to_reg(commit_rob_id_to_reg),
        .commit_store_to_lsb(commit_store_to_lsb), .commit_rob_id_to_lsb(commit_rob_id_to_lsb),
        .rollback_flag(rollback_flag), .target_pc_to_if(target_pc_to_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        rdy, ena, st, br, pd;
        logic [4:0]  rd;
        logic        rv;
        logic [4:0]  rid;
        logic [31:0] rres;
        logic        rtk;
        logic [31:0] rtgt;
        logic        lv;
        logic [4:0]  lid;
        logic [31:0] lres;
        logic [4:0]  q1, q2;
    } stim_t;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [31:0] val, tgt;
        logic        st, br, pd, tk, rdy;
    } ent_t;

    typedef struct {
        int          tag;
        logic        ena, st, rb;
        logic [4:0]  rd;
        logic [31:0] data, tpc;
        int          id;
    } exp_t;

    ent_t rob[$];
    exp_t sb[$];
    int   next_id = 1;
    logic flush_m = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic int find_id(int id);
        foreach (rob[i]) if (rob[i].id == id) return i;
        return -1;
    endfunction

    // One clock of the reference model: retire a ready head, capture CDBs, allocate.
    function automatic void model_step(stim_t s);
        ent_t e;
        exp_t x;
        int   k;
        int   size0;
        if (!s.rdy) return;
        if (flush_m) begin
            rob.delete();
            next_id = 1;
            flush_m = 1'b0;
            return;
        end
        size0 = rob.size();
        if (size0 > 0 && rob[0].rdy) begin
            e     = rob.pop_front();
            x.tag = cyc + 1;
            x.ena = (e.rd != 0) && !e.st;
            x.st  = e.st;
            x.rb  = e.br && (e.tk != e.pd);
            x.rd  = e.rd;
            x.data = e.val;
            x.id  = e.id;
            x.tpc = e.tgt;
            if (x.ena || x.st || x.rb) sb.push_back(x);
            if (x.rb) flush_m = 1'b1;
        end
        if (s.rv) begin
            k = find_id(int'(s.rid));
            if (k >= 0) begin
                rob[k].rdy = 1'b1;
                rob[k].val = s.rres;
                rob[k].tk  = s.rtk;
                rob[k].tgt = s.rtgt;
            end
        end
        if (s.lv) begin
            k = find_id(int'(s.lid));
            if (k >= 0) begin
                rob[k].rdy = 1'b1;
                rob[k].val = s.lres;
            end
        end
        if (s.ena && size0 < DEPTH) begin
            e = '{id: next_id, rd: s.rd, val: '0, tgt: '0, st: s.st, br: s.br,
                  pd: s.pd, tk: 1'b0, rdy: 1'b0};
            rob.push_back(e);
            next_id = next_id % DEPTH + 1;
        end
    endfunction

    function automatic void check_query(string nm, logic [4:0] q, logic r, logic [31:0] d);
        int k;
        if (q == 0) begin
            check({nm, "_ready_id0"}, 32'(r), 0);
            check({nm, "_data_id0"}, d, 0);
        end else begin
            k = find_id(int'(q));
            if (k >= 0 && rob[k].rdy) begin
                check({nm, "_ready"}, 32'(r), 1);
                check({nm, "_data"}, d, rob[k].val);
            end else begin
                check({nm, "_notready"}, 32'(r), 0);
            end
        end
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        s.rdy = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rdy                   = s.rdy;
        ena_from_dsp          = s.ena;
        rd_from_dsp           = s.rd;
        is_store_from_dsp     = s.st;
        is_branch_from_dsp    = s.br;
        pred_taken_from_dsp   = s.pd;
        valid_from_rs_cdb     = s.rv;
        rob_id_from_rs_cdb    = s.rid;
        result_from_rs_cdb    = s.rres;
        taken_from_rs_cdb     = s.rtk;
        target_pc_from_rs_cdb = s.rtgt;
        valid_from_ls_cdb     = s.lv;
        rob_id_from_ls_cdb    = s.lid;
        result_from_ls_cdb    = s.lres;
        Q1_from_dsp           = s.q1;
        Q2_from_dsp           = s.q2;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_cycle(input stim_t s);
        drive(s);
        #1;
        check("rob_id_to_dsp", 32'(rob_id_to_dsp), next_id);
        check("full_to_if", 32'(full_to_if), (rob.size() >= DEPTH - 2) ? 1 : 0);
        check_query("q1", s.q1, Q1_ready_to_dsp, data1_to_dsp);
        check_query("q2", s.q2, Q2_ready_to_dsp, data2_to_dsp);
        model_step(s);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(idle_stim());
        rst = 1'b1;
        rob.delete();
        sb.delete();
        next_id = 1;
        flush_m = 1'b0;
        #1;
        check("rst_pulses", {29'd0, commit_ena_to_reg, commit_store_to_lsb, rollback_flag}, 0);
        check("rst_reg_data", commit_data_to_reg, 0);
        check("rst_ids", {17'd0, commit_rd_to_reg, commit_rob_id_to_reg, commit_rob_id_to_lsb}, 0);
        check("rst_target_pc", target_pc_to_if, 0);
        check("rst_rob_id", 32'(rob_id_to_dsp), 1);
        check("rst_full", 32'(full_to_if), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic stim_t gen_stim();
        stim_t s;
        int    k;
        s      = idle_stim();
        s.rdy  = flush_m ? 1'b1 : ($urandom_range(19) != 0);
        s.ena  = ($urandom_range(3) != 0);
        s.rd   = 5'($urandom);
        s.st   = ($urandom_range(5) == 0);
        s.br   = !s.st && ($urandom_range(4) == 0);
        s.pd   = 1'($urandom);
        s.rres = $urandom;
        s.rtgt = $urandom;
        s.lres = $urandom;
        if (rob.size() > 0 && $urandom_range(9) < 6) begin
            k = $urandom_range(rob.size() - 1);
            if (!rob[k].st) begin
                s.rv  = 1'b1;
                s.rid = 5'(rob[k].id);
                s.rtk = ($urandom_range(3) == 0) ? !rob[k].pd : rob[k].pd;
            end
        end else if ($urandom_range(7) == 0) begin
            s.rv  = 1'b1;
            s.rid = 5'($urandom_range(DEPTH));
            s.rtk = 1'($urandom);
        end
        if (rob.size() > 0 && $urandom_range(1) == 0) begin
            k = $urandom_range(rob.size() - 1);
            if (!rob[k].br) begin
                s.lv  = 1'b1;
                s.lid = 5'(rob[k].id);
            end
        end
        if (s.lv && s.rv && s.lid == s.rid) s.lv = 1'b0;
        s.q1 = 5'($urandom_range(DEPTH));
        s.q2 = (rob.size() > 0) ? 5'(rob[$urandom_range(rob.size() - 1)].id) : 5'd0;
        return s;
    endfunction

    // Commit monitor: pops the scoreboard whenever a commit is due or one appears.
    always begin : monitor
        exp_t       e;
        logic [2:0] p;
        @(posedge clk);
        #1;
        if (!rst) begin
            p = {commit_ena_to_reg, commit_store_to_lsb, rollback_flag};
            if (sb.size() > 0 && sb[0].tag == cyc) begin
                e = sb.pop_front();
                check("commit_pulses", 32'(p), 32'({e.ena, e.st, e.rb}));
                if (e.ena) begin
                    check("commit_rd", 32'(commit_rd_to_reg), 32'(e.rd));
                    check("commit_data", commit_data_to_reg, e.data);
                    check("commit_reg_id", 32'(commit_rob_id_to_reg), e.id);
                end
                if (e.st) check("commit_lsb_id", 32'(commit_rob_id_to_lsb), e.id);
                if (e.rb) check("rollback_target", target_pc_to_if, e.tpc);
            end else if (p != 3'b000) begin
                check("unexpected_commit", 32'(p), 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        stim_t s;
        #2;
        do_reset();

        // Basic alloc / out-of-order CDB / in-order commit
        for (int k = 1; k <= 3; k++) begin
            check("alloc_id", 32'(rob_id_to_dsp), k);
            s = idle_stim(); s.ena = 1'b1; s.rd = 5'(k);
            do_cycle(s);
        end
        s = idle_stim(); s.rv = 1'b1; s.rid = 5'd2; s.rres = 32'h22; do_cycle(s);
        s = idle_stim(); s.rv = 1'b1; s.rid = 5'd1; s.rres = 32'h11; do_cycle(s);
        for (int k = 0; k < 3; k++) begin
            s = idle_stim(); s.q1 = 5'd3; do_cycle(s);
        end

        // Fill to capacity, drop the overflow alloc, wrap the tail
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            s = idle_stim(); s.ena = 1'b1; s.rd = 5'(k); do_cycle(s);
        end
        check("full_at_14", 32'(full_to_if), 1);
        for (int k = 15; k <= 17; k++) begin
            s = idle_stim(); s.ena = 1'b1; s.rd = 5'(k); do_cycle(s);
        end
        check("wrapped_rob_id", 32'(rob_id_to_dsp), 1);
        s = idle_stim(); s.rv = 1'b1; s.rid = 5'd1; s.rres = 32'hA1; do_cycle(s);
        s = idle_stim(); do_cycle(s);
        s = idle_stim(); s.ena = 1'b1; s.rd = 5'd9; do_cycle(s);
        check("realloc_next_id", 32'(rob_id_to_dsp), 2);

        // Operand query
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            s = idle_stim(); s.ena = 1'b1; s.rd = 5'(k + 10); do_cycle(s);
        end
        s = idle_stim(); s.rv = 1'b1; s.rid = 5'd5; s.rres = 32'hDEAD; do_cycle(s);
        Q1_from_dsp = 5'd5;
        Q2_from_dsp = 5'd0;
        #1;
        check("q1_id5_ready", 32'(Q1_ready_to_dsp), 1);
        check("q1_id5_data", data1_to_dsp, 32'hDEAD);
        check("q2_id0_ready", 32'(Q2_ready_to_dsp), 0);
        check("q2_id0_data", data2_to_dsp, 0);
        s = idle_stim(); s.q1 = 5'd5; do_cycle(s);

        // Store release
        do_reset();
        s = idle_stim(); s.ena = 1'b1; s.st = 1'b1; s.rd = 5'd7; do_cycle(s);
        s = idle_stim(); s.lv = 1'b1; s.lid = 5'd1; s.lres = 32'hABCD; do_cycle(s);
        s = idle_stim(); do_cycle(s);
        s = idle_stim(); do_cycle(s);

        // Mispredict with younger entries
        do_reset();
        s = idle_stim(); s.ena = 1'b1; s.br = 1'b1; s.pd = 1'b0; do_cycle(s);
        for (int k = 1; k <= 3; k++) begin
            s = idle_stim(); s.ena = 1'b1; s.rd = 5'(k); do_cycle(s);
        end
        s = idle_stim(); s.rv = 1'b1; s.rid = 5'd1; s.rtk = 1'b1;
        s.rtgt = 32'h1000; s.rres = 32'h4; do_cycle(s);
        s = idle_stim(); do_cycle(s);
        s = idle_stim(); s.q1 = 5'd2; do_cycle(s);
        check("post_rollback_id", 32'(rob_id_to_dsp), 1);
        check("post_rollback_full", 32'(full_to_if), 0);
        s = idle_stim(); s.ena = 1'b1; s.rd = 5'd4; do_cycle(s);

        // Alloc + commit + dual CDB in one cycle, then reset mid-stream
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            s = idle_stim(); s.ena = 1'b1; s.rd = 5'(k + 3); do_cycle(s);
        end
        s = idle_stim(); s.rv = 1'b1; s.rid = 5'd1; s.rres = 32'h101; do_cycle(s);
        s = idle_stim(); s.ena = 1'b1; s.rd = 5'd8;
        s.rv = 1'b1; s.rid = 5'd2; s.rres = 32'h202;
        s.lv = 1'b1; s.lid = 5'd3; s.lres = 32'h303;
        s.q1 = 5'd2; do_cycle(s);
        check("alloc_commit_next_id", 32'(rob_id_to_dsp), 5);
        s = idle_stim(); s.q1 = 5'd2; s.q2 = 5'd3; do_cycle(s);
        #2;
        do_reset();

        // Random traffic with one asynchronous reset in the middle
        for (int i = 0; i < 1500; i++) begin
            s = gen_stim();
            do_cycle(s);
            if (i == 700) begin
                #2;
                do_reset();
            end
        end
        s = idle_stim();
        drive(s);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
